// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives the pipelined mpadder with the raw op,
// then an optional -M/+M correction, and presents a registered reduced result.
module mod_addsub_ctrl #(
  parameter int W = 1027
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_in_a,
  output logic [W-1:0] add_in_b,
  input  logic [W:0]   add_result,
  input  logic         add_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] OP1   = 3'd1;
  localparam logic [2:0] WAIT1 = 3'd2;
  localparam logic [2:0] OP2   = 3'd3;
  localparam logic [2:0] WAIT2 = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  logic [2:0]   state_q,    state_d;
  logic         sub_q,      sub_d;
  logic [W-1:0] m_q,        m_d;
  logic [W-1:0] t_q,        t_d;
  logic [W-1:0] result_q,   result_d;
  logic [W-1:0] addInA_q,   addInA_d;
  logic [W-1:0] addInB_q,   addInB_d;
  logic         addSub_q,   addSub_d;
  logic         addStart_q, addStart_d;
  logic         busy_q,     busy_d;
  logic         done_q,     done_d;

  // Every output is computed one state ahead so it is a plain register in the
  // state it belongs to; the operand registers double as the latched A/B.
  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    m_d        = m_q;
    t_d        = t_q;
    result_d   = result_q;
    addInA_d   = addInA_q;
    addInB_d   = addInB_q;
    addSub_d   = addSub_q;
    addStart_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sub_d      = subtract;
          m_d        = in_m;
          addInA_d   = in_a;
          addInB_d   = in_b;
          addSub_d   = subtract;
          addStart_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = OP1;
        end
      end
      OP1:  state_d = WAIT1;
      WAIT1: begin
        if (add_done) begin
          t_d = add_result[W-1:0];
          // An add always needs the trial T-M; a sub only when it went negative.
          if (!sub_q || add_result[W]) begin
            addInA_d   = add_result[W-1:0];
            addInB_d   = m_q;
            addSub_d   = ~sub_q;
            addStart_d = 1'b1;
            state_d    = OP2;
          end else begin
            result_d = add_result[W-1:0];
            done_d   = 1'b1;
            state_d  = FIN;
          end
        end
      end
      OP2:  state_d = WAIT2;
      WAIT2: begin
        if (add_done) begin
          // Borrow on T-M means T was already reduced.
          if (!sub_q && add_result[W]) result_d = t_q;
          else                         result_d = add_result[W-1:0];
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sub_q      <= 1'b0;
      m_q        <= '0;
      t_q        <= '0;
      result_q   <= '0;
      addInA_q   <= '0;
      addInB_q   <= '0;
      addSub_q   <= 1'b0;
      addStart_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      m_q        <= m_d;
      t_q        <= t_d;
      result_q   <= result_d;
      addInA_q   <= addInA_d;
      addInB_q   <= addInB_d;
      addSub_q   <= addSub_d;
      addStart_q <= addStart_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign add_start    = addStart_q;
  assign add_subtract = addSub_q;
  assign add_in_a     = addInA_q;
  assign add_in_b     = addInB_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl with a behavioural one-cycle mpadder and a modular
// arithmetic reference model.
module tb_mod_addsub_ctrl;
  localparam int W = 1027;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         subtract = 1'b0;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic [W-1:0] inM = '0;
  logic         busy, done, addStart, addSub, addDone;
  logic [W-1:0] result, addInA, addInB;
  logic [W:0]   addResult;

  int checkCount = 0;
  int failCount = 0;
  int startPulses = 0;

  mod_addsub_ctrl #(.W(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(inA), .in_b(inB), .in_m(inM),
    .busy(busy), .done(done), .result(result),
    .add_start(addStart), .add_subtract(addSub),
    .add_in_a(addInA), .add_in_b(addInB),
    .add_result(addResult), .add_done(addDone)
  );

  always #5 clk = ~clk;

  // Stand-in for mpadder: result and done appear one cycle after add_start.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addDone   <= 1'b0;
      addResult <= '0;
    end else begin
      addDone <= addStart;
      if (addStart)
        addResult <= addSub ? ({1'b0, addInA} - {1'b0, addInB})
                            : ({1'b0, addInA} + {1'b0, addInB});
    end
  end

  always @(posedge clk) if (resetn && addStart) startPulses <= startPulses + 1;

  function automatic logic [W-1:0] refModel(input logic sub, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (a >= b) begin
      s = {1'b0, a - b};
    end else begin
      s = {1'b0, (m - b) + a};
    end
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 33; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Waits for IDLE, issues one request, and returns cycles until done and the
  // number of add_start pulses seen. With holdStart, start stays high afterwards.
  task automatic applyStimulus(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] m, input bit holdStart,
                               output int cyc, output int pulses);
    int p0;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    subtract = sub; inA = a; inB = b; inM = m; start = 1'b1;
    p0 = startPulses;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!holdStart) start = 1'b0;
      if (holdStart && cyc == 1) begin
        inA = ~a; inB = ~b; subtract = ~sub;
      end
      checkOutput("busy_during_op", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
    end while (!done && cyc < 20);
    pulses = startPulses - p0;
  endtask

  task automatic runAndCheck(input string tag, input logic sub, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] m, input bit holdStart);
    int cyc, pulses;
    logic [W-1:0] exp;
    exp = refModel(sub, a, b, m);
    applyStimulus(sub, a, b, m, holdStart, cyc, pulses);
    checkOutput({tag, "_result"}, {1'b0, result}, {1'b0, exp});
    checkOutput({tag, "_latency"}, (W+1)'(cyc), (W+1)'((sub && a >= b) ? 3 : 5));
    checkOutput({tag, "_pulses"}, (W+1)'(pulses), (W+1)'((sub && a >= b) ? 1 : 2));
  endtask

  initial begin
    logic [W-1:0] bigM, rm, ra, rb;
    logic rs;
    bit sawDone;
    int shift;

    #12;
    checkOutput("reset_busy", {{W{1'b0}}, busy}, '0);
    checkOutput("reset_done", {{W{1'b0}}, done}, '0);
    checkOutput("reset_result", {1'b0, result}, '0);
    checkOutput("reset_add_start", {{W{1'b0}}, addStart}, '0);
    checkOutput("reset_add_in_a", {1'b0, addInA}, '0);
    @(negedge clk);
    resetn = 1'b1;

    runAndCheck("add_5_7", 1'b0, W'(5), W'(7), W'(11), 1'b0);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", {{W{1'b0}}, done}, '0);
    checkOutput("result_held", {1'b0, result}, (W+1)'(1));
    runAndCheck("add_3_4", 1'b0, W'(3), W'(4), W'(11), 1'b0);
    runAndCheck("sub_9_4", 1'b1, W'(9), W'(4), W'(11), 1'b0);
    runAndCheck("sub_2_9", 1'b1, W'(2), W'(9), W'(11), 1'b0);
    runAndCheck("sub_equal", 1'b1, W'(6), W'(6), W'(11), 1'b0);

    bigM = {2'b00, {(W-2){1'b1}}};
    runAndCheck("big_add", 1'b0, bigM - 1, bigM - 1, bigM, 1'b0);
    runAndCheck("big_sub", 1'b1, '0, bigM - 1, bigM, 1'b0);

    // Start held through the whole op, operands scrambled after acceptance.
    runAndCheck("hold_start", 1'b0, W'(8), W'(9), W'(13), 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("fin_start_ignored", {{W{1'b0}}, busy}, '0);

    // Reset while WAIT1 is active: everything clears at once and no done follows.
    @(negedge clk);
    subtract = 1'b0; inA = W'(10); inB = W'(10); inM = W'(11); start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checkOutput("abort_busy", {{W{1'b0}}, busy}, '0);
    checkOutput("abort_result", {1'b0, result}, '0);
    checkOutput("abort_add_start", {{W{1'b0}}, addStart}, '0);
    checkOutput("abort_add_in_b", {1'b0, addInB}, '0);
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", {{W{1'b0}}, sawDone}, '0);
    runAndCheck("after_abort", 1'b0, W'(10), W'(10), W'(11), 1'b0);

    for (int n = 0; n < 12; n++) begin
      shift = $urandom_range(2, 1020);
      rm = randWide() >> shift;
      if (rm == '0) rm = W'(1);
      ra = randWide() % rm;
      rb = (n % 4 == 0) ? ra : randWide() % rm;
      rs = 1'($urandom_range(0, 1));
      runAndCheck($sformatf("rand%0d", n), rs, ra, rb, rm, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
